// File: rtl/uart.sv
// Full-duplex 8N1 UART bridging AXI-Stream byte ports to txd/rxd serial pins.
// Bit period is 8*prescale clocks, latched per frame and per bit (0 acts as 1).
module uart #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           prescale,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error
);

    localparam int unsigned CNT_W = 19;
    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // Bit period and half-period reload values, both minus one for down-counting to zero.
    logic [15:0]      ps_eff_c;
    logic [CNT_W-1:0] bit_m1_c;
    logic [CNT_W-1:0] half_m1_c;

    assign ps_eff_c  = (prescale == 16'd0) ? 16'd1 : prescale;
    assign bit_m1_c  = {ps_eff_c, 3'b000} - CNT_W'(1);
    assign half_m1_c = {1'b0, ps_eff_c, 2'b00} - CNT_W'(1);

    // ---------------- transmit ----------------
    state_e                tx_state_q;
    logic [CNT_W-1:0]      tx_cnt_q;
    logic [BIT_W-1:0]      tx_bit_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  txd_q;
    logic                  tx_ready_q;
    logic                  tx_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    tx_ready_q <= 1'b1;
                    if (tx_ready_q && s_axis_tvalid) begin
                        tx_data_q  <= s_axis_tdata;
                        tx_ready_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= bit_m1_c;
                        tx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q != '0) begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end else begin
                        txd_q      <= tx_data_q[0];
                        tx_data_q  <= tx_data_q >> 1;
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= bit_m1_c;
                        tx_state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q != '0) begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end else begin
                        tx_cnt_q <= bit_m1_c;
                        if (tx_bit_q == LAST_BIT) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= ST_STOP;
                        end else begin
                            txd_q     <= tx_data_q[0];
                            tx_data_q <= tx_data_q >> 1;
                            tx_bit_q  <= tx_bit_q + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_q != '0) begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end else begin
                        tx_ready_q <= 1'b1;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= ST_IDLE;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign txd           = txd_q;
    assign s_axis_tready = tx_ready_q;
    assign tx_busy       = tx_busy_q;

    // ---------------- receive ----------------
    state_e                rx_state_q;
    logic [CNT_W-1:0]      rx_cnt_q;
    logic [BIT_W-1:0]      rx_bit_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic                  rxd_meta_q;
    logic                  rxd_sync_q;
    logic                  rx_armed_q;
    logic                  rx_busy_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_valid_q;
    logic                  overrun_q;
    logic                  frame_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rx_armed_q <= 1'b0;
            rx_busy_q  <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
            if (m_valid_q && m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
            case (rx_state_q)
                // A start is only recognised once the line has been seen high here.
                ST_IDLE: begin
                    if (rxd_sync_q) begin
                        rx_armed_q <= 1'b1;
                    end else if (rx_armed_q) begin
                        rx_armed_q <= 1'b0;
                        rx_busy_q  <= 1'b1;
                        rx_cnt_q   <= half_m1_c;
                        rx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    end else if (rxd_sync_q) begin
                        rx_busy_q  <= 1'b0;
                        rx_state_q <= ST_IDLE;
                    end else begin
                        rx_bit_q   <= '0;
                        rx_cnt_q   <= bit_m1_c;
                        rx_state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    end else begin
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                        rx_cnt_q   <= bit_m1_c;
                        if (rx_bit_q == LAST_BIT) begin
                            rx_state_q <= ST_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    end else begin
                        rx_busy_q  <= 1'b0;
                        rx_state_q <= ST_IDLE;
                        if (rxd_sync_q) begin
                            m_data_q  <= rx_shift_q;
                            m_valid_q <= 1'b1;
                            overrun_q <= m_valid_q && !m_axis_tready;
                        end else begin
                            frame_q <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata     = m_data_q;
    assign m_axis_tvalid    = m_valid_q;
    assign rx_busy          = rx_busy_q;
    assign rx_overrun_error = overrun_q;
    assign rx_frame_error   = frame_q;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: serial frames are built and decoded from the 8N1
// framing rules directly, with expected bytes kept in tables and queues.
module tb_uart;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        txd;
    logic        tx_busy;
    logic        rx_busy;
    logic        rx_overrun_error;
    logic        rx_frame_error;

    always #5 clk = ~clk;

    uart #(.DATA_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .prescale         (prescale),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rxd              (rxd),
        .txd              (txd),
        .tx_busy          (tx_busy),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error)
    );

    logic [7:0] msg [11] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20,
                             8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64};

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rx_got [$];
    int         busy_runs [$];
    int         ovr_cnt   = 0;
    int         frm_cnt   = 0;
    int         busy_run  = 0;
    int         ready_vio = 0;

    // Observers: accepted RX bytes, error pulses, and length of each tx_busy window.
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) rx_got.push_back(m_axis_tdata);
        if (rx_overrun_error) ovr_cnt++;
        if (rx_frame_error) frm_cnt++;
        if (tx_busy) begin
            busy_run++;
            if (s_axis_tready) ready_vio++;
        end else if (busy_run != 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
    end

    task automatic send_tx(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_accept_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, guard);
        end
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    // Decode one frame from txd: find the start edge, then sample each bit centre.
    task automatic capture_tx(input int cpb, output logic [7:0] b, output logic stop, output logic ok);
        int guard;
        guard = 0;
        ok    = 1'b1;
        b     = '0;
        stop  = 1'b0;
        while (txd !== 1'b0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            ok = 1'b0;
        end else begin
            repeat (cpb / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (cpb) @(negedge clk);
                b[i] = txd;
            end
            repeat (cpb) @(negedge clk);
            stop = txd;
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int cpb);
        @(negedge clk);
        rxd = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (cpb) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (cpb) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        prescale      = 16'd1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        rxd           = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({txd, s_axis_tready, tx_busy, m_axis_tvalid, rx_busy, rx_overrun_error, rx_frame_error} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_status: {txd,tready,txbusy,mvalid,rxbusy,ovr,frm}=%b required 1000000",
                     {txd, s_axis_tready, tx_busy, m_axis_tvalid, rx_busy, rx_overrun_error, rx_frame_error});
        end
        n_cmp++;
        if (m_axis_tdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_tdata: got %h required 00", m_axis_tdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tready_release: got %b required 1", s_axis_tready);
        end
        n_cmp++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_txd_idle: got %b required 1", txd);
        end
    endtask

    task automatic test_reset_midframe();
        send_tx(8'h00);
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({txd, tx_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL midframe_active: {txd,busy}=%b required 01", {txd, tx_busy});
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({txd, tx_busy, s_axis_tready} !== 3'b100) begin
            n_bad++;
            $display("FAIL midframe_abort: {txd,busy,tready}=%b required 100", {txd, tx_busy, s_axis_tready});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx();
        logic [7:0] b;
        logic       stop;
        logic       ok;
        int         vio0;
        prescale = 16'd1;
        busy_runs.delete();
        vio0 = ready_vio;
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    send_tx(msg[i]);
                    repeat ($urandom_range(49, 0)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 11; i++) begin
                    capture_tx(8, b, stop, ok);
                    n_cmp++;
                    if (ok !== 1'b1 || b !== msg[i]) begin
                        n_bad++;
                        $display("FAIL tx_byte[%0d]: got %h (found=%b) required %h", i, b, ok, msg[i]);
                    end
                    n_cmp++;
                    if (stop !== 1'b1) begin
                        n_bad++;
                        $display("FAIL tx_stop[%0d]: got %b required 1", i, stop);
                    end
                end
            end
        join
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy_runs.size() != 11) begin
            n_bad++;
            $display("FAIL tx_busy_windows: got %0d required 11", busy_runs.size());
        end
        for (int i = 0; i < busy_runs.size(); i++) begin
            n_cmp++;
            if (busy_runs[i] != 80) begin
                n_bad++;
                $display("FAIL tx_busy_len[%0d]: got %0d required 80", i, busy_runs[i]);
            end
        end
        n_cmp++;
        if (ready_vio != vio0) begin
            n_bad++;
            $display("FAIL tx_ready_while_busy: got %0d cycles required 0", ready_vio - vio0);
        end
    endtask

    task automatic test_rx();
        int o0;
        int f0;
        prescale      = 16'd1;
        m_axis_tready = 1'b1;
        rx_got.delete();
        o0 = ovr_cnt;
        f0 = frm_cnt;
        for (int i = 0; i < 11; i++) begin
            drive_rx(msg[i], 1'b1, 8);
            repeat ($urandom_range(49, 0)) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (rx_got.size() != 11) begin
            n_bad++;
            $display("FAIL rx_count: got %0d required 11", rx_got.size());
        end
        for (int i = 0; i < 11 && i < rx_got.size(); i++) begin
            n_cmp++;
            if (rx_got[i] !== msg[i]) begin
                n_bad++;
                $display("FAIL rx_byte[%0d]: got %h required %h", i, rx_got[i], msg[i]);
            end
        end
        n_cmp++;
        if ((ovr_cnt - o0) != 0 || (frm_cnt - f0) != 0) begin
            n_bad++;
            $display("FAIL rx_errors: overrun=%0d frame=%0d required 0/0", ovr_cnt - o0, frm_cnt - f0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        m_axis_tready = 1'b0;
        rx_got.delete();
        o0 = ovr_cnt;
        drive_rx(8'h55, 1'b1, 8);
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h55}) begin
            n_bad++;
            $display("FAIL ovr_first: valid=%b data=%h required 1/55", m_axis_tvalid, m_axis_tdata);
        end
        drive_rx(8'hAA, 1'b1, 8);
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'hAA}) begin
            n_bad++;
            $display("FAIL ovr_second: valid=%b data=%h required 1/aa", m_axis_tvalid, m_axis_tdata);
        end
        n_cmp++;
        if (ovr_cnt - o0 != 1) begin
            n_bad++;
            $display("FAIL ovr_pulses: got %0d required 1", ovr_cnt - o0);
        end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_valid_clear: got %b required 0", m_axis_tvalid);
        end
        n_cmp++;
        if (rx_got.size() != 1 || rx_got[0] !== 8'hAA) begin
            n_bad++;
            $display("FAIL ovr_delivered: count=%0d first=%h required 1/aa", rx_got.size(),
                     (rx_got.size() > 0) ? rx_got[0] : 8'h00);
        end
    endtask

    task automatic test_framing();
        int f0;
        m_axis_tready = 1'b1;
        rx_got.delete();
        f0 = frm_cnt;
        drive_rx(8'h3C, 1'b0, 8);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (frm_cnt - f0 != 1) begin
            n_bad++;
            $display("FAIL frm_pulses: got %0d required 1", frm_cnt - f0);
        end
        n_cmp++;
        if (rx_got.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL frm_no_byte: count=%0d valid=%b required 0/0", rx_got.size(), m_axis_tvalid);
        end
        drive_rx(8'hC3, 1'b1, 8);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rx_got.size() != 1 || rx_got[0] !== 8'hC3) begin
            n_bad++;
            $display("FAIL frm_recover: count=%0d first=%h required 1/c3", rx_got.size(),
                     (rx_got.size() > 0) ? rx_got[0] : 8'h00);
        end
        n_cmp++;
        if (frm_cnt - f0 != 1) begin
            n_bad++;
            $display("FAIL frm_no_extra: got %0d required 1", frm_cnt - f0);
        end
    endtask

    task automatic test_concurrency();
        logic [7:0] b;
        logic       stop;
        logic       ok;
        int         f0;
        prescale      = 16'd4;
        m_axis_tready = 1'b1;
        busy_runs.delete();
        rx_got.delete();
        f0 = frm_cnt;
        fork
            send_tx(8'hA5);
            capture_tx(32, b, stop, ok);
            begin
                @(negedge clk);
                rxd = 1'b0;
                repeat (3) @(negedge clk);
                rxd = 1'b1;
                repeat (40) @(negedge clk);
                n_cmp++;
                if (rx_got.size() != 0) begin
                    n_bad++;
                    $display("FAIL glitch_no_byte: count=%0d required 0", rx_got.size());
                end
                drive_rx(8'hA5, 1'b1, 32);
            end
        join
        repeat (40) @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || b !== 8'hA5 || stop !== 1'b1) begin
            n_bad++;
            $display("FAIL conc_tx: byte=%h stop=%b found=%b required a5/1/1", b, stop, ok);
        end
        n_cmp++;
        if (rx_got.size() != 1 || rx_got[0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL conc_rx: count=%0d first=%h required 1/a5", rx_got.size(),
                     (rx_got.size() > 0) ? rx_got[0] : 8'h00);
        end
        n_cmp++;
        if (busy_runs.size() != 1 || busy_runs[0] != 320) begin
            n_bad++;
            $display("FAIL conc_busy_len: windows=%0d len=%0d required 1/320", busy_runs.size(),
                     (busy_runs.size() > 0) ? busy_runs[0] : 0);
        end
        n_cmp++;
        if (frm_cnt - f0 != 0) begin
            n_bad++;
            $display("FAIL conc_frame_err: got %0d required 0", frm_cnt - f0);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_tx();
        test_rx();
        test_overrun();
        test_framing();
        test_concurrency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
